// File: rtl/shift_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl_pkg
// Shared definitions for the shift sequencer: data/amount widths, the state
// encoding, the largest per-pass shift and the step-size helper.
// -----------------------------------------------------------------------------
package shift_seq_ctrl_pkg;

   localparam int DATA_W = 8;  // fixed: matches the 8-bit shifter stage
   localparam int AMT_W  = 5;  // total shift amounts 0..31

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [2:0] MAX_STEP = 3'd7;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      SHIFT = ST_SHIFT,
      DONE  = ST_DONE
   } state_t;

   // Size of the next pass: min(rem, MAX_STEP). Never exceeds rem, so the
   // remainder cannot underflow.
   function automatic logic [2:0] calc_step(input logic [AMT_W-1:0] rem);
      logic [2:0] step;
      if (rem >= {{(AMT_W-3){1'b0}}, MAX_STEP}) begin
         step = MAX_STEP;
      end else begin
         step = rem[2:0];
      end
      return step;
   endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl_if
// Request/result handshake bundle of the shift sequencer.
//   in_valid/in_ready/in_data/in_amt   : request channel (source -> sequencer)
//   out_valid/out_ready/out_data       : result channel (sequencer -> consumer)
//   busy                               : sequencer is working on or holding a result
// master: the environment driving requests and consuming results.
// slave : the sequencer itself.
// -----------------------------------------------------------------------------
interface shift_seq_ctrl_if;
   import shift_seq_ctrl_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [AMT_W-1:0]  in_amt;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              busy;

   modport master (
      output in_valid, in_data, in_amt, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, in_data, in_amt, out_ready,
      output in_ready, out_valid, out_data, busy
   );

endinterface

// File: rtl/shift_seq_ctrl_shr8_stage.sv
// -----------------------------------------------------------------------------
// shr8_stage
// Purely combinational 8-bit logical right shifter, 0..7 bits, zero fill,
// built as three mux layers (shift by 4, then 2, then 1).
//   data_in  [7:0]  operand
//   amt      [2:0]  shift amount
//   data_out [7:0]  data_in >> amt
// -----------------------------------------------------------------------------
module shr8_stage (
   input  logic [7:0] data_in,
   input  logic [2:0] amt,
   output logic [7:0] data_out
);

   logic [7:0] lvl4_s;
   logic [7:0] lvl2_s;

   assign lvl4_s   = amt[2] ? {4'b0000, data_in[7:4]} : data_in;
   assign lvl2_s   = amt[1] ? {2'b00,   lvl4_s[7:2]}  : lvl4_s;
   assign data_out = amt[0] ? {1'b0,    lvl2_s[7:1]}  : lvl2_s;

endmodule

// File: rtl/shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl
// Sequencing front-end for the 8-bit, max-7-bit-per-pass right shifter.
// Accepts one request (operand + total amount up to 31), applies it as a
// series of passes of at most 7 bits, registering the intermediate value after
// each pass, then presents the result on a valid/ready port.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : shift_seq_ctrl_if.slave (request, result and busy signals)
// All bus outputs come straight from flops; they are loaded from the
// next-state decode so they line up with the state register.
// -----------------------------------------------------------------------------
module shift_seq_ctrl
   import shift_seq_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   shift_seq_ctrl_if.slave  bus
);

   state_t            state_r;
   state_t            state_nxt_s;
   logic [DATA_W-1:0] data_r;
   logic [DATA_W-1:0] data_nxt_s;
   logic [AMT_W-1:0]  rem_r;
   logic [AMT_W-1:0]  rem_nxt_s;
   logic [AMT_W-1:0]  rem_left_s;
   logic [DATA_W-1:0] out_data_r;
   logic [DATA_W-1:0] out_data_nxt_s;
   logic              in_ready_r;
   logic              out_valid_r;
   logic              busy_r;
   logic [2:0]        step_s;
   logic [DATA_W-1:0] shr_out_s;

   assign step_s     = calc_step(rem_r);
   assign rem_left_s = rem_r - {{(AMT_W-3){1'b0}}, step_s};

   shr8_stage u_shr8_stage (
      .data_in  (data_r),
      .amt      (step_s),
      .data_out (shr_out_s)
   );

   // Next-state, datapath and result-capture decode.
   always_comb begin
      state_nxt_s    = state_r;
      data_nxt_s     = data_r;
      rem_nxt_s      = rem_r;
      out_data_nxt_s = out_data_r;
      case (state_r)
         IDLE: begin
            if (bus.in_valid) begin
               data_nxt_s  = bus.in_data;
               rem_nxt_s   = bus.in_amt;
               state_nxt_s = SHIFT;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SHIFT: begin
            // A zero amount still takes one pass with step 0.
            data_nxt_s = shr_out_s;
            rem_nxt_s  = rem_left_s;
            if (rem_left_s == {AMT_W{1'b0}}) begin
               out_data_nxt_s = shr_out_s;
               state_nxt_s    = DONE;
            end else begin
               state_nxt_s = SHIFT;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State, datapath and registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         data_r      <= {DATA_W{1'b0}};
         rem_r       <= {AMT_W{1'b0}};
         out_data_r  <= {DATA_W{1'b0}};
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         data_r      <= data_nxt_s;
         rem_r       <= rem_nxt_s;
         out_data_r  <= out_data_nxt_s;
         in_ready_r  <= (state_nxt_s == IDLE);
         out_valid_r <= (state_nxt_s == DONE);
         busy_r      <= (state_nxt_s != IDLE);
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;
   assign bus.busy      = busy_r;

endmodule
